// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and types for the forwarding / hazard unit.
package fwd_hazard_unit_pkg;

    // Forwarding select encoding seen by the EX operand muxes
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Register 0 is hardwired to zero and must never be forwarded
    localparam int unsigned RF_ZERO = 0;

    // Bubble counter width, wide enough for up to 4 load-use bubbles
    localparam int BUB_W = 3;

    typedef enum logic {
        RUN = 1'b0,
        LU  = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the pipeline control and the forwarding / hazard unit.
interface fwd_hazard_unit_if #(
    parameter int RA_W    = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic                      id_valid;
    logic [NUM_SRC*RA_W-1:0]   id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [RA_W-1:0]           ex_dst;
    logic [RA_W-1:0]           mem_dst;
    logic [RA_W-1:0]           wb_dst;
    logic                      ex_rw;
    logic                      mem_rw;
    logic                      wb_rw;
    logic                      ex_is_load;
    logic                      mem_busy;
    logic                      flush;
    logic                      cnt_clr;
    logic [2*NUM_SRC-1:0]      fwd_sel;
    logic                      stall_if;
    logic                      stall_id;
    logic                      bubble_ex;
    logic                      freeze;
    logic [CNT_W-1:0]          stall_cnt;

    // Pipeline side: supplies stage info, consumes selects and stalls
    modport master (
        output id_valid, id_src, id_src_used,
        output ex_dst, mem_dst, wb_dst, ex_rw, mem_rw, wb_rw,
        output ex_is_load, mem_busy, flush, cnt_clr,
        input  fwd_sel, stall_if, stall_id, bubble_ex, freeze, stall_cnt
    );

    // Hazard unit side
    modport slave (
        input  id_valid, id_src, id_src_used,
        input  ex_dst, mem_dst, wb_dst, ex_rw, mem_rw, wb_rw,
        input  ex_is_load, mem_busy, flush, cnt_clr,
        output fwd_sel, stall_if, stall_id, bubble_ex, freeze, stall_cnt
    );

endinterface

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Single-source forwarding priority compare (EX > MEM > WB > regfile).
module fwd_select
    import fwd_hazard_unit_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic            used,
    input  logic [RA_W-1:0] ex_dst,
    input  logic            ex_rw,
    input  logic [RA_W-1:0] mem_dst,
    input  logic            mem_rw,
    input  logic [RA_W-1:0] wb_dst,
    input  logic            wb_rw,
    output logic [1:0]      sel,
    output logic            ex_match
);

    logic mem_match;
    logic wb_match;

    // A stage only matches a source that is really read and a non-zero writer
    assign ex_match  = used & ex_rw  & (ex_dst  != RA_W'(RF_ZERO)) & (ex_dst  == src);
    assign mem_match = used & mem_rw & (mem_dst != RA_W'(RF_ZERO)) & (mem_dst == src);
    assign wb_match  = used & wb_rw  & (wb_dst  != RA_W'(RF_ZERO)) & (wb_dst  == src);

    // Youngest producer wins
    always_comb begin
        sel = FWD_RF;
        if (ex_match) begin
            sel = FWD_EX;
        end else if (mem_match) begin
            sel = FWD_MEM;
        end else if (wb_match) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select generation plus load-use stall, freeze and flush control.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int RA_W       = 5,
    parameter int NUM_SRC    = 2,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               rst_n,
    fwd_hazard_unit_if.slave  hz
);

    localparam logic [BUB_W-1:0] LU_LOAD = BUB_W'(LU_BUBBLES - 1);

    logic [2*NUM_SRC-1:0] sel_raw;
    logic [NUM_SRC-1:0]   ex_match;
    logic                 lu_hit;
    hz_state_t            state;
    logic [BUB_W-1:0]     bub_cnt;
    logic [CNT_W-1:0]     stall_cnt;
    logic                 stall_if;
    logic                 stall_id;
    logic                 bubble_ex;
    logic                 freeze;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_select #(.RA_W(RA_W)) u_sel (
                .src      (hz.id_src[i*RA_W +: RA_W]),
                .used     (hz.id_src_used[i]),
                .ex_dst   (hz.ex_dst),
                .ex_rw    (hz.ex_rw),
                .mem_dst  (hz.mem_dst),
                .mem_rw   (hz.mem_rw),
                .wb_dst   (hz.wb_dst),
                .wb_rw    (hz.wb_rw),
                .sel      (sel_raw[2*i +: 2]),
                .ex_match (ex_match[i])
            );
        end
    endgenerate

    // ex_match already carries ex_rw, dst != 0 and source-used qualification
    assign lu_hit = hz.id_valid & hz.ex_is_load & (|ex_match);

    // Stall controls: reset, then freeze, then flush, then load-use
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        freeze    = 1'b0;
        if (!rst_n) begin
            freeze = 1'b0;
        end else if (hz.mem_busy) begin
            freeze   = 1'b1;
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (hz.flush) begin
            stall_if = 1'b0;
        end else if (state == LU || lu_hit) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    // Bubble FSM: holds on freeze, cleared by flush, lu_hit ignored while in LU
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            bub_cnt <= '0;
        end else if (hz.mem_busy) begin
            state   <= state;
            bub_cnt <= bub_cnt;
        end else if (hz.flush) begin
            state   <= RUN;
            bub_cnt <= '0;
        end else if (state == LU) begin
            if (bub_cnt == BUB_W'(1)) begin
                state   <= RUN;
                bub_cnt <= '0;
            end else begin
                bub_cnt <= bub_cnt - BUB_W'(1);
            end
        end else if (lu_hit && (LU_BUBBLES > 1)) begin
            state   <= LU;
            bub_cnt <= LU_LOAD;
        end
    end

    // Saturating stalled-cycle statistic; clear wins over increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hz.cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall_id) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign hz.fwd_sel   = rst_n ? sel_raw : '0;
    assign hz.stall_if  = stall_if;
    assign hz.stall_id  = stall_id;
    assign hz.bubble_ex = bubble_ex;
    assign hz.freeze    = freeze;
    assign hz.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench: three instances cover LU_BUBBLES = 1, 2 and 3 (CNT_W = 4).
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [9:0] id_src;
    logic [1:0] id_src_used;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic       ex_rw, mem_rw, wb_rw;
    logic       ex_is_load, mem_busy, flush, cnt_clr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.RA_W(5), .NUM_SRC(2), .CNT_W(16)) bus1 ();
    fwd_hazard_unit_if #(.RA_W(5), .NUM_SRC(2), .CNT_W(16)) bus2 ();
    fwd_hazard_unit_if #(.RA_W(5), .NUM_SRC(2), .CNT_W(4))  bus3 ();

    assign bus1.id_valid = id_valid;  assign bus1.id_src = id_src;  assign bus1.id_src_used = id_src_used;
    assign bus1.ex_dst = ex_dst;  assign bus1.mem_dst = mem_dst;  assign bus1.wb_dst = wb_dst;
    assign bus1.ex_rw = ex_rw;  assign bus1.mem_rw = mem_rw;  assign bus1.wb_rw = wb_rw;
    assign bus1.ex_is_load = ex_is_load;  assign bus1.mem_busy = mem_busy;
    assign bus1.flush = flush;  assign bus1.cnt_clr = cnt_clr;

    assign bus2.id_valid = id_valid;  assign bus2.id_src = id_src;  assign bus2.id_src_used = id_src_used;
    assign bus2.ex_dst = ex_dst;  assign bus2.mem_dst = mem_dst;  assign bus2.wb_dst = wb_dst;
    assign bus2.ex_rw = ex_rw;  assign bus2.mem_rw = mem_rw;  assign bus2.wb_rw = wb_rw;
    assign bus2.ex_is_load = ex_is_load;  assign bus2.mem_busy = mem_busy;
    assign bus2.flush = flush;  assign bus2.cnt_clr = cnt_clr;

    assign bus3.id_valid = id_valid;  assign bus3.id_src = id_src;  assign bus3.id_src_used = id_src_used;
    assign bus3.ex_dst = ex_dst;  assign bus3.mem_dst = mem_dst;  assign bus3.wb_dst = wb_dst;
    assign bus3.ex_rw = ex_rw;  assign bus3.mem_rw = mem_rw;  assign bus3.wb_rw = wb_rw;
    assign bus3.ex_is_load = ex_is_load;  assign bus3.mem_busy = mem_busy;
    assign bus3.flush = flush;  assign bus3.cnt_clr = cnt_clr;

    fwd_hazard_unit #(.RA_W(5), .NUM_SRC(2), .LU_BUBBLES(1), .CNT_W(16)) u_b1 (
        .clk(clk), .rst_n(rst_n), .hz(bus1.slave));
    fwd_hazard_unit #(.RA_W(5), .NUM_SRC(2), .LU_BUBBLES(2), .CNT_W(16)) u_b2 (
        .clk(clk), .rst_n(rst_n), .hz(bus2.slave));
    fwd_hazard_unit #(.RA_W(5), .NUM_SRC(2), .LU_BUBBLES(3), .CNT_W(4)) u_b3 (
        .clk(clk), .rst_n(rst_n), .hz(bus3.slave));

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_src = '0; id_src_used = '0;
        ex_dst = '0; mem_dst = '0; wb_dst = '0;
        ex_rw = 1'b0; mem_rw = 1'b0; wb_rw = 1'b0;
        ex_is_load = 1'b0; mem_busy = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
    endtask

    // Load in EX writing r7, ID reads r7 on source 1 only
    task automatic load_use();
        id_valid = 1'b1; id_src = {5'd7, 5'd0}; id_src_used = 2'b10;
        ex_dst = 5'd7; ex_rw = 1'b1; ex_is_load = 1'b1;
    endtask

    // Load has moved on: EX holds a bubble, load result sits in MEM
    task automatic load_gone();
        ex_is_load = 1'b0; ex_rw = 1'b0; ex_dst = '0;
        mem_dst = 5'd7; mem_rw = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;

        // Reset forcing: inputs would forward, stall and freeze
        load_use();
        mem_busy = 1'b1;
        #1;
        check_vec("rst_fwd_sel", 32'(bus1.fwd_sel), 32'h0);
        check_vec("rst_stalls", {29'd0, bus2.stall_if, bus2.stall_id, bus2.bubble_ex}, 32'h0);
        check_vec("rst_freeze", 32'(bus2.freeze), 32'h0);
        tick();
        tick();
        check_vec("rst_cnt", 32'(bus2.stall_cnt), 32'h0);
        rst_n = 1'b1;
        idle();

        // Forwarding priority
        id_valid = 1'b1; id_src = {5'd3, 5'd3}; id_src_used = 2'b11;
        ex_dst = 5'd3; mem_dst = 5'd3; wb_dst = 5'd3;
        ex_rw = 1'b1; mem_rw = 1'b1; wb_rw = 1'b1;
        #1 check_vec("prio_ex", 32'(bus1.fwd_sel), 32'b0101);
        check_vec("prio_nostall", 32'(bus1.stall_id), 32'h0);
        ex_rw = 1'b0;
        #1 check_vec("prio_mem", 32'(bus1.fwd_sel), 32'b1010);
        mem_rw = 1'b0;
        #1 check_vec("prio_wb", 32'(bus1.fwd_sel), 32'b1111);

        // Register zero never forwards, and a load to r0 never stalls
        id_src = {5'd0, 5'd0}; ex_dst = '0; mem_dst = '0; wb_dst = '0;
        ex_rw = 1'b1; mem_rw = 1'b1; wb_rw = 1'b1; ex_is_load = 1'b1;
        #1 check_vec("zero_fwd", 32'(bus1.fwd_sel[1:0]), 32'h0);
        check_vec("zero_nostall", 32'(bus1.stall_id), 32'h0);
        ex_is_load = 1'b0; mem_rw = 1'b0; wb_rw = 1'b0;
        id_src = {5'd0, 5'd4}; id_src_used = 2'b10; ex_dst = 5'd4;
        #1 check_vec("unused_src", 32'(bus1.fwd_sel), 32'h0);
        tick();
        idle();

        // Load-use, one bubble
        do_reset();
        load_use();
        #1 check_vec("lu1_c1", {29'd0, bus1.stall_if, bus1.stall_id, bus1.bubble_ex}, 32'b111);
        tick();
        load_gone();
        #1 check_vec("lu1_c2", {29'd0, bus1.stall_if, bus1.stall_id, bus1.bubble_ex}, 32'b000);
        check_vec("lu1_cnt", 32'(bus1.stall_cnt), 32'd1);
        check_vec("lu1_fwd_mem", 32'(bus1.fwd_sel), 32'b1000);

        // Load-use, two bubbles, no freeze
        do_reset();
        load_use();
        #1 check_vec("lu2_c1", {29'd0, bus2.stall_if, bus2.stall_id, bus2.bubble_ex}, 32'b111);
        tick();
        load_gone();
        #1 check_vec("lu2_c2", {29'd0, bus2.stall_if, bus2.stall_id, bus2.bubble_ex}, 32'b111);
        tick();
        #1 check_vec("lu2_c3", 32'(bus2.stall_id), 32'h0);
        check_vec("lu2_cnt", 32'(bus2.stall_cnt), 32'd2);

        // Load-use, two bubbles, memory busy for 3 cycles in the second slot
        do_reset();
        load_use();
        #1 check_vec("lu2f_c1", 32'(bus2.bubble_ex), 32'h1);
        tick();
        mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check_vec($sformatf("frz_%0d", k),
                         {28'd0, bus2.freeze, bus2.stall_if, bus2.stall_id, bus2.bubble_ex}, 32'b1110);
            tick();
        end
        mem_busy = 1'b0;
        #1 check_vec("lu2f_last", {28'd0, bus2.freeze, bus2.stall_if, bus2.stall_id, bus2.bubble_ex},
                     32'b0111);
        tick();
        load_gone();
        #1 check_vec("lu2f_done", 32'(bus2.stall_id), 32'h0);
        check_vec("lu2f_cnt", 32'(bus2.stall_cnt), 32'd5);

        // mem_busy beats flush
        mem_busy = 1'b1; flush = 1'b1;
        #1 check_vec("busy_vs_flush", {29'd0, bus2.freeze, bus2.stall_id, bus2.bubble_ex}, 32'b110);
        mem_busy = 1'b0; flush = 1'b0;

        // Flush in LU with three bubbles
        do_reset();
        load_use();
        #1 check_vec("fl_c1", 32'(bus3.stall_id), 32'h1);
        tick();
        flush = 1'b1;
        #1 check_vec("fl_c2", {29'd0, bus3.stall_if, bus3.stall_id, bus3.bubble_ex}, 32'b000);
        tick();
        flush = 1'b0;
        load_gone();
        #1 check_vec("fl_run", 32'(bus3.stall_id), 32'h0);
        check_vec("fl_cnt", 32'(bus3.stall_cnt), 32'd1);
        tick();

        // Flush together with lu_hit
        idle();
        load_use();
        flush = 1'b1;
        #1 check_vec("fl_lu_same", {29'd0, bus3.stall_if, bus3.stall_id, bus3.bubble_ex}, 32'b000);
        tick();
        flush = 1'b0;
        load_gone();
        #1 check_vec("fl_lu_run", 32'(bus3.stall_id), 32'h0);
        check_vec("fl_cnt_hold", 32'(bus3.stall_cnt), 32'd1);
        tick();

        // Saturation of a 4-bit counter under continuous stalling
        idle();
        load_use();
        for (int k = 0; k < 13; k++) tick();
        check_vec("sat_14", 32'(bus3.stall_cnt), 32'd14);
        for (int k = 0; k < 7; k++) tick();
        check_vec("sat_hold", 32'(bus3.stall_cnt), 32'd15);
        cnt_clr = 1'b1;
        #1 check_vec("clr_stalling", 32'(bus3.stall_id), 32'h1);
        tick();
        check_vec("clr_cnt", 32'(bus3.stall_cnt), 32'd0);
        cnt_clr = 1'b0;

        // Reset in the middle of LU
        do_reset();
        load_use();
        tick();
        rst_n = 1'b0;
        #1 check_vec("rstlu_stalls", {28'd0, bus3.freeze, bus3.stall_if, bus3.stall_id, bus3.bubble_ex},
                     32'h0);
        check_vec("rstlu_fwd", 32'(bus3.fwd_sel), 32'h0);
        tick();
        rst_n = 1'b1;
        load_gone();
        #1 check_vec("rstlu_run", 32'(bus3.stall_id), 32'h0);
        check_vec("rstlu_cnt", 32'(bus3.stall_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
